circle_point_engine: RTL

//  Bresenham midpoint circle rasteriser. Takes a centre, radius and colour from the

---
 rtl/circle_point_engine_if.sv | 21 ++
 rtl/circle_point_engine.sv | 137 +++++++++++++
 2 files changed

// File: rtl/circle_point_engine_if.sv
// Parameter-source and pixel-sink signals of the circle rasteriser.
// The engine uses the slave modport; the driver/sink side uses master.
interface circle_point_engine_if;
   logic       start;
   logic [7:0] xc;
   logic [6:0] yc;
   logic [7:0] radius;
   logic [2:0] colour;
   logic       plot_ready;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [2:0] plot_colour;
   logic       plot_valid;
   logic       busy;
   logic       done;

   modport master (output start, xc, yc, radius, colour, plot_ready,
                   input  plot_x, plot_y, plot_colour, plot_valid, busy, done);
   modport slave  (input  start, xc, yc, radius, colour, plot_ready,
                   output plot_x, plot_y, plot_colour, plot_valid, busy, done);
endinterface

// File: rtl/circle_point_engine.sv
// Midpoint circle rasteriser: one on-screen octant point per handshake,
// off-screen points dropped in one cycle each.
module circle_point_engine #(
   parameter int X_MAX = 160,
   parameter int Y_MAX = 120,
   parameter int DW    = 12
) (
   input  logic                  clock,
   input  logic                  resetn,
   circle_point_engine_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LOAD, PLOT, STEP, DONE} state_t;

   state_t                state, n_state;
   logic [7:0]            xc_r, n_xc, rad_r, n_rad, x, n_x, y, n_y;
   logic [6:0]            yc_r, n_yc;
   logic [2:0]            col_r, n_col, oct, n_oct;
   logic signed [DW-1:0]  d, n_d, xs, ys;
   logic signed [9:0]     cx, cy, ax, ay, px, py, stx, sty;
   logic                  pix_ok;
   logic [7:0]            px_o;
   logic [6:0]            py_o;
   logic                  valid_o, busy_o, done_o;

   always_comb begin
      n_state = state;
      n_xc    = xc_r;
      n_yc    = yc_r;
      n_rad   = rad_r;
      n_col   = col_r;
      n_x     = x;
      n_y     = y;
      n_d     = d;
      n_oct   = oct;
      xs      = DW'(x);
      ys      = DW'(y);
      stx     = $signed({2'b00, x}) + 10'sd1;
      sty     = $signed({2'b00, y}) - (d[DW-1] ? 10'sd0 : 10'sd1);
      unique case (state)
         IDLE: if (bus.start) begin
            n_xc    = bus.xc;
            n_yc    = bus.yc;
            n_rad   = bus.radius;
            n_col   = bus.colour;
            n_state = LOAD;
         end
         LOAD: begin
            n_x     = 8'd0;
            n_y     = rad_r;
            n_d     = DW'(3) - (DW'(rad_r) <<< 1);
            n_oct   = 3'd0;
            n_state = PLOT;
         end
         // A held pixel (valid, not ready) keeps oct and therefore its coordinates
         PLOT: if (!valid_o || bus.plot_ready) begin
            if (oct == 3'd7) n_state = STEP;
            else             n_oct   = oct + 3'd1;
         end
         STEP: begin
            if (d[DW-1]) n_d = d + (xs <<< 2) + DW'(6);
            else begin
               n_d = d + ((xs - ys) <<< 2) + DW'(10);
               n_y = y - 8'd1;
            end
            n_x     = x + 8'd1;
            n_oct   = 3'd0;
            // Signed compare: y may step below zero when radius is 0
            n_state = (stx > sty) ? DONE : PLOT;
         end
         DONE:    n_state = IDLE;
         default: n_state = IDLE;
      endcase
   end

   // Evaluate the point for the next cycle so the pixel outputs are registered
   always_comb begin
      cx = $signed({2'b00, n_xc});
      cy = $signed({3'b000, n_yc});
      ax = $signed({2'b00, n_x});
      ay = $signed({2'b00, n_y});
      unique case (n_oct)
         3'd0: begin px = cx + ax; py = cy + ay; end
         3'd1: begin px = cx - ax; py = cy + ay; end
         3'd2: begin px = cx + ax; py = cy - ay; end
         3'd3: begin px = cx - ax; py = cy - ay; end
         3'd4: begin px = cx + ay; py = cy + ax; end
         3'd5: begin px = cx - ay; py = cy + ax; end
         3'd6: begin px = cx + ay; py = cy - ax; end
         default: begin px = cx - ay; py = cy - ax; end
      endcase
      pix_ok = (n_state == PLOT) && !px[9] && (px < 10'(X_MAX))
                                 && !py[9] && (py < 10'(Y_MAX));
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state   <= IDLE;
         xc_r    <= '0;
         yc_r    <= '0;
         rad_r   <= '0;
         col_r   <= '0;
         x       <= '0;
         y       <= '0;
         d       <= '0;
         oct     <= '0;
         px_o    <= '0;
         py_o    <= '0;
         valid_o <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         state   <= n_state;
         xc_r    <= n_xc;
         yc_r    <= n_yc;
         rad_r   <= n_rad;
         col_r   <= n_col;
         x       <= n_x;
         y       <= n_y;
         d       <= n_d;
         oct     <= n_oct;
         valid_o <= pix_ok;
         busy_o  <= (n_state != IDLE);
         done_o  <= (n_state == DONE);
         if (pix_ok) begin
            px_o <= px[7:0];
            py_o <= py[6:0];
         end
      end
   end

   assign bus.plot_x      = px_o;
   assign bus.plot_y      = py_o;
   assign bus.plot_colour = col_r;
   assign bus.plot_valid  = valid_o;
   assign bus.busy        = busy_o;
   assign bus.done        = done_o;
endmodule
